// File: rtl/convcore_z_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : convcore_z_reader_pkg
// Purpose  : Shared types and constants for the MEMZ drain reader.
//            - zr_state_t : readout FSM states.
//            - CFG_*_FIELD: field index of sizeX / sizeY inside the packed
//              configuration word. The bit offset is field * ADDR_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
package convcore_z_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } zr_state_t;

  localparam int CFG_SIZEX_FIELD = 0;
  localparam int CFG_SIZEY_FIELD = 1;

endpackage
`default_nettype wire

// File: rtl/convcore_z_reader_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : zread_skid_fifo
// Purpose  : Two-entry FIFO holding MEMZ words returned to the reader.
// Ports    : clk, rstn  - clock, async active-low reset
//            push, din  - write strobe / data (ignored when full, no pop)
//            pop        - remove head (ignored when empty)
//            dout       - current head word (register mux)
//            full, empty, count - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module zread_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = rd_ptr ? mem1 : mem0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) mem1 <= din;
        else        mem0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/convcore_z_reader.sv
`default_nettype none
// ============================================================================
// Module   : convcore_z_reader
// Purpose  : After a convolution completes, reads sizeX+sizeY-1 result words
//            from MEMZ (addresses 0..len-1) and streams them out over a
//            valid/ready interface.
// Ports    : clk, rstn           - clock, async active-low reset
//            start, config_in    - readout request, packed {sizeY, sizeX}
//            memZ_addr, memZ_re  - MEMZ read request (registered)
//            dataZ_in            - MEMZ read data, captured on the clock edge
//                                  that closes the memZ_re cycle
//            m_data/m_valid/m_ready/m_last - output stream
//            busy_out, done_out  - status (done_out is a one-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
module convcore_z_reader
  import convcore_z_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [2*ADDR_WIDTH-1:0] config_in,
  output logic [ADDR_WIDTH:0]     memZ_addr,
  output logic                    memZ_re,
  input  logic [2*DATA_WIDTH-1:0] dataZ_in,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam int CW = ADDR_WIDTH + 1;

  zr_state_t             state;
  logic [CW-1:0]         len;
  logic [CW-1:0]         issued;
  logic [CW-1:0]         sent;
  logic [ADDR_WIDTH-1:0] size_x;
  logic [ADDR_WIDTH-1:0] size_y;
  logic [CW-1:0]         cfg_len;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic [1:0]            count_next;

  assign size_x  = config_in[CFG_SIZEX_FIELD*ADDR_WIDTH +: ADDR_WIDTH];
  assign size_y  = config_in[CFG_SIZEY_FIELD*ADDR_WIDTH +: ADDR_WIDTH];
  assign cfg_len = ((size_x == '0) || (size_y == '0)) ? '0 :
                   (CW'(size_x) + CW'(size_y) - CW'(1));

  // A read issued this cycle is the single read in flight; its data is
  // captured into the FIFO on the closing edge.
  assign inflight = memZ_re;
  assign push     = inflight;
  assign pop      = m_valid && m_ready;

  // Occupancy after the coming edge. Issuing the next read only while this
  // is below 2 keeps occupancy + in-flight within the two FIFO entries.
  assign count_next = fifo_count + {1'b0, push} - {1'b0, pop};

  zread_skid_fifo #(
    .WIDTH (2*DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (dataZ_in),
    .pop   (pop),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign m_last  = m_valid && (sent == len - CW'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      len       <= '0;
      issued    <= '0;
      sent      <= '0;
      memZ_re   <= 1'b0;
      memZ_addr <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      if (pop) sent <= sent + CW'(1);
      case (state)
        ST_IDLE: begin
          done_out <= 1'b0;
          if (start) begin
            len      <= cfg_len;
            sent     <= '0;
            busy_out <= 1'b1;
            if (cfg_len != '0) begin
              state     <= ST_READ;
              memZ_re   <= 1'b1;
              memZ_addr <= '0;
              issued    <= CW'(1);
            end else begin
              state    <= ST_FIN;
              issued   <= '0;
              done_out <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issued == len) begin
            memZ_re <= 1'b0;
            state   <= ST_DRAIN;
          end else if (count_next < 2'd2) begin
            memZ_re   <= 1'b1;
            memZ_addr <= issued;
            issued    <= issued + CW'(1);
          end else begin
            memZ_re <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (pop && (sent == len - CW'(1))) begin
            state    <= ST_FIN;
            done_out <= 1'b1;
          end
        end
        ST_FIN: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
